// File: rtl/stage_fetch_if.sv
// -----------------------------------------------------------------------------
// stage_fetch_if
//   Bundles the fetch stage's two handshakes. The instruction-bus side covers
//   mem_req/mem_addr/mem_ready/mem_rvalid/mem_rdata. The decode side covers
//   pc_out/instr/instr_valid/stall/discard. It also carries the redirect from
//   execute.
//
//   modport master : the fetch stage (drives mem_req, mem_addr, pc_out,
//                    instr, instr_valid; samples everything else)
//   modport slave  : the environment around it (memory, decode, execute)
// -----------------------------------------------------------------------------
interface stage_fetch_if;
   // instruction bus
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   // decode side
   logic        stall;
   logic        discard;
   logic [31:0] pc_out;
   logic [31:0] instr;
   logic        instr_valid;
   // execute side
   logic        redirect_valid;
   logic [31:0] redirect_target;

   modport master (
      output mem_req, mem_addr, pc_out, instr, instr_valid,
      input  mem_ready, mem_rvalid, mem_rdata, stall, discard,
             redirect_valid, redirect_target
   );

   modport slave (
      input  mem_req, mem_addr, pc_out, instr, instr_valid,
      output mem_ready, mem_rvalid, mem_rdata, stall, discard,
             redirect_valid, redirect_target
   );
endinterface

// File: rtl/stage_fetch.sv
// -----------------------------------------------------------------------------
// stage_fetch
//   Instruction fetch stage. Each in-order word read on the instruction bus is
//   issued and given an entry in a small in-order buffer, which records the PC
//   for that request. The stage presents the head entry to decode once its data
//   has returned, and holds it while decode stalls. On discard, all fetched and
//   in-flight work is dropped, and the stage waits for execute's redirect. On a
//   redirect, fetch restarts at the target.
//
//   Parameters
//     RESET_PC : fetch address after reset
//     DEPTH    : buffer entries (power of two, >= 2); this bounds the number of
//                outstanding plus buffered fetches
//   Ports
//     clk, rst : clock; asynchronous active-high reset
//     fe       : stage_fetch_if.master (instruction bus, decode and redirect)
// -----------------------------------------------------------------------------
module stage_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic           clk,
   input  logic           rst,
   stage_fetch_if.master  fe
);

   localparam int PW = $clog2(DEPTH);

   // The pointers carry one extra bit so that a full buffer and an empty
   // buffer are distinguishable. The drop counter has the same width.
   typedef logic [PW:0]   ptr_t;
   typedef logic [PW-1:0] idx_t;

   typedef enum logic {
      ST_RUN,
      ST_WAIT_REDIRECT
   } state_t;

   state_t          state_q,    state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   ptr_t            alloc_q,    alloc_d;
   ptr_t            fill_q,     fill_d;
   ptr_t            head_q,     head_d;
   ptr_t            drop_q,     drop_d;
   logic [31:0]     ent_pc_q     [DEPTH];
   logic [31:0]     ent_pc_d     [DEPTH];
   logic [31:0]     ent_data_q   [DEPTH];
   logic [31:0]     ent_data_d   [DEPTH];
   logic [DEPTH-1:0] ent_filled_q, ent_filled_d;

   ptr_t occupancy;
   idx_t alloc_idx, fill_idx, head_idx;
   logic issue_en, accept, resp_keep, resp_drop, present, pop, flush;

   assign occupancy = alloc_q - head_q;
   assign alloc_idx = alloc_q[PW-1:0];
   assign fill_idx  = fill_q[PW-1:0];
   assign head_idx  = head_q[PW-1:0];

   // Occupancy counts in-flight entries as well as filled ones, so the bus can
   // never return more words than the buffer has room for.
   assign issue_en  = (state_q == ST_RUN) && (occupancy < ptr_t'(DEPTH)) &&
                      !fe.discard && !fe.redirect_valid;
   // Mask the request while reset is held, so that the bus sees nothing.
   assign fe.mem_req  = issue_en && !rst;
   assign fe.mem_addr = fetch_pc_q;
   assign accept      = fe.mem_req && fe.mem_ready;

   assign resp_keep = fe.mem_rvalid && (drop_q == '0);
   assign resp_drop = fe.mem_rvalid && (drop_q != '0);

   assign present        = ent_filled_q[head_idx] && (state_q == ST_RUN) && !fe.discard;
   assign fe.instr_valid = present;
   assign fe.pc_out      = ent_pc_q[head_idx];
   assign fe.instr       = ent_data_q[head_idx];
   assign pop            = present && !fe.stall;

   // A discard in RUN flushes the buffer. A redirect flushes from any state.
   assign flush = fe.redirect_valid || ((state_q == ST_RUN) && fe.discard);

   // NOTE: every *_d is given its hold value before any branch; a path that
   // leaves a combinational output unassigned would infer a latch.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      alloc_d      = alloc_q;
      fill_d       = fill_q;
      head_d       = head_q;
      drop_d       = drop_q;
      ent_pc_d     = ent_pc_q;
      ent_data_d   = ent_data_q;
      ent_filled_d = ent_filled_q;

      if (accept) begin
         ent_pc_d[alloc_idx]     = fetch_pc_q;
         ent_filled_d[alloc_idx] = 1'b0;
         alloc_d                 = alloc_q + ptr_t'(1);
         fetch_pc_d              = fetch_pc_q + 32'd4;
      end

      if (resp_keep) begin
         ent_data_d[fill_idx]   = fe.mem_rdata;
         ent_filled_d[fill_idx] = 1'b1;
         fill_d                 = fill_q + ptr_t'(1);
      end

      if (resp_drop)
         drop_d = drop_q - ptr_t'(1);

      // Clear the filled bit on pop. Otherwise, a stale entry could be
      // presented again when the head wraps onto it before it is reallocated.
      if (pop) begin
         ent_filled_d[head_idx] = 1'b0;
         head_d                 = head_q + ptr_t'(1);
      end

      unique case (state_q)
         ST_RUN:           if (fe.discard && !fe.redirect_valid) state_d = ST_WAIT_REDIRECT;
         ST_WAIT_REDIRECT: ;
         default:          state_d = ST_RUN;
      endcase

      if (flush) begin
         ent_filled_d = '0;
         head_d       = alloc_d;
         fill_d       = alloc_d;
         // Every bus word that is still owed becomes a drop. These are the
         // unfilled entries, plus anything accepted now. A response that
         // arrives in this cycle is one of those words, so it is subtracted
         // from the count. This holds whether it would have been kept or
         // dropped.
         drop_d = drop_q + ptr_t'(alloc_q - fill_q) + ptr_t'(accept)
                  - ptr_t'(fe.mem_rvalid);
      end

      if (fe.redirect_valid) begin
         fetch_pc_d = {fe.redirect_target[31:2], 2'b00};
         state_d    = ST_RUN;
      end
   end

   // NOTE: state is updated only with non-blocking assignments, so that every
   // register samples the pre-edge values regardless of evaluation order.
   // NOTE: the buffer entries are reset as well. The buffer is tiny, and
   // clearing it makes pc_out/instr read zero out of reset without extra muxing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         fetch_pc_q   <= RESET_PC;
         alloc_q      <= '0;
         fill_q       <= '0;
         head_q       <= '0;
         drop_q       <= '0;
         ent_pc_q     <= '{default: '0};
         ent_data_q   <= '{default: '0};
         ent_filled_q <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         alloc_q      <= alloc_d;
         fill_q       <= fill_d;
         head_q       <= head_d;
         drop_q       <= drop_d;
         ent_pc_q     <= ent_pc_d;
         ent_data_q   <= ent_data_d;
         ent_filled_q <= ent_filled_d;
      end
   end

endmodule

// File: tb/tb_stage_fetch.sv
// -----------------------------------------------------------------------------
// tb_stage_fetch
//   Table-driven bench for stage_fetch. There are two instances: one with
//   RESET_PC=0 driven by a memory responder, and one with
//   RESET_PC=0xFFFFFFFC for the address-wrap case. Inputs change on the falling
//   edge, and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_stage_fetch;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stage_fetch_if mif ();
   stage_fetch_if mif2 ();

   stage_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk (clk), .rst (rst), .fe (mif)
   );

   stage_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
      .clk (clk), .rst (rst), .fe (mif2)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit hold     = 1'b0;   // withhold memory responses while set

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t pend_q[$];

   typedef struct {
      bit          rst_before;
      bit          stall;
      bit          discard;
      bit          redir;
      logic [31:0] target;
      bit          ready;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_iv;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   function automatic vec_t mk(input bit rb, input bit st, input bit dis, input bit rv,
                               input logic [31:0] tgt, input bit rdy, input bit ereq,
                               input logic [31:0] eaddr, input bit eiv,
                               input logic [31:0] epc);
      vec_t v;
      v.rst_before = rb;  v.stall = st;   v.discard = dis; v.redir = rv;
      v.target = tgt;     v.ready = rdy;  v.exp_req = ereq; v.exp_addr = eaddr;
      v.exp_iv = eiv;     v.exp_pc = epc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sample_accept();
      pend_t p;
      if (mif.mem_req === 1'b1 && mif.mem_ready === 1'b1) begin
         p.addr = mif.mem_addr;
         p.due  = cyc + 1;
         pend_q.push_back(p);
      end
   endtask

   // One clock cycle: deliver a due response, apply the inputs, then record
   // any request the DUT will have accepted at the coming rising edge.
   task automatic step(input bit st, input bit dis, input bit rv,
                       input logic [31:0] tgt, input bit rdy);
      @(negedge clk);
      cyc++;
      if (pend_q.size() > 0 && !hold && pend_q[0].due <= cyc) begin
         mif.mem_rvalid = 1'b1;
         mif.mem_rdata  = mem_word(pend_q[0].addr);
         void'(pend_q.pop_front());
      end else begin
         mif.mem_rvalid = 1'b0;
         mif.mem_rdata  = 32'h0;
      end
      mif.stall           = st;
      mif.discard         = dis;
      mif.redirect_valid  = rv;
      mif.redirect_target = tgt;
      mif.mem_ready       = rdy;
      #1;
      sample_accept();
   endtask

   task automatic check_out(input string tag, input bit ereq, input logic [31:0] eaddr,
                            input bit eiv, input logic [31:0] epc);
      check({tag, " mem_req"}, {31'b0, mif.mem_req}, {31'b0, ereq});
      if (ereq) check({tag, " mem_addr"}, mif.mem_addr, eaddr);
      check({tag, " instr_valid"}, {31'b0, mif.instr_valid}, {31'b0, eiv});
      if (eiv) begin
         check({tag, " pc_out"}, mif.pc_out, epc);
         check({tag, " instr"}, mif.instr, mem_word(epc));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst                 = 1'b1;
      hold                = 1'b0;
      pend_q.delete();
      mif.mem_rvalid      = 1'b0;
      mif.mem_rdata       = 32'h0;
      mif.stall           = 1'b0;
      mif.discard         = 1'b0;
      mif.redirect_valid  = 1'b0;
      mif.redirect_target = 32'h0;
      mif.mem_ready       = 1'b1;
      #1;
      check("reset mem_req", {31'b0, mif.mem_req}, 32'h0);
      check("reset instr_valid", {31'b0, mif.instr_valid}, 32'h0);
      check("reset pc_out", mif.pc_out, 32'h0);
      check("reset instr", mif.instr, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cyc = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mif2.mem_ready       = 1'b1;
      mif2.mem_rvalid      = 1'b0;
      mif2.mem_rdata       = 32'h0;
      mif2.stall           = 1'b0;
      mif2.discard         = 1'b0;
      mif2.redirect_valid  = 1'b0;
      mif2.redirect_target = 32'h0;
      rst = 1'b1;

      // Streaming with mem_ready=1, 1-cycle responses and no stall.
      vecs.push_back(mk(1,0,0,0,0,1, 1,32'h0,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h4,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,      1,32'h0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h8,  1,32'h4));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'hC,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,      1,32'h8));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h10, 1,32'hC));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h14, 0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,      1,32'h10));
      // A 6-cycle stall holds pc 0, and nothing is lost or duplicated afterwards.
      vecs.push_back(mk(1,0,0,0,0,1, 1,32'h0,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h4,  0,0));
      for (int k = 0; k < 6; k++)
         vecs.push_back(mk(0,1,0,0,0,1, 0,0,   1,32'h0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,      1,32'h0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h8,  1,32'h4));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'hC,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,      1,32'h8));
      // mem_ready is low for 3 cycles, and the request holds address 0x8.
      vecs.push_back(mk(1,0,0,0,0,1, 1,32'h0,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h4,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,      1,32'h0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,32'h8,  1,32'h4));
      vecs.push_back(mk(0,0,0,0,0,0, 1,32'h8,  0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,32'h8,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h8,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'hC,  0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,      1,32'h8));
      // An unaligned redirect is forced to word alignment, and a redirect wins
      // over a simultaneous discard.
      vecs.push_back(mk(1,0,1,1,32'h103,1, 0,0, 0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h100, 0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,32'h104, 0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,       1,32'h100));

      foreach (vecs[i]) begin
         if (vecs[i].rst_before) do_reset();
         step(vecs[i].stall, vecs[i].discard, vecs[i].redir, vecs[i].target, vecs[i].ready);
         check_out($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                   vecs[i].exp_iv, vecs[i].exp_pc);
      end

      // Discard with two requests in flight. Both responses are dropped, and
      // fetch resumes only at the redirect target.
      do_reset();
      hold = 1'b1;
      step(0,0,0,0,1);        check_out("disc c0", 1, 32'h0, 0, 0);
      step(0,0,0,0,1);        check_out("disc c1", 1, 32'h4, 0, 0);
      step(0,0,0,0,1);        check_out("disc c2", 0, 0, 0, 0);
      step(0,1,0,0,1);        check_out("disc c3", 0, 0, 0, 0);
      hold = 1'b0;
      step(0,0,0,0,1);        check_out("disc c4", 0, 0, 0, 0);
      step(0,0,0,0,1);        check_out("disc c5", 0, 0, 0, 0);
      step(0,0,1,32'h100,1);  check_out("disc c6", 0, 0, 0, 0);
      step(0,0,0,0,1);        check_out("disc c7", 1, 32'h100, 0, 0);
      step(0,0,0,0,1);        check_out("disc c8", 1, 32'h104, 0, 0);
      step(0,0,0,0,1);        check_out("disc c9", 0, 0, 1, 32'h100);

      // A response that arrives in the flush cycle counts as dropped, so the
      // next response after the redirect must still be kept.
      do_reset();
      step(0,0,0,0,1);        check_out("fresp c0", 1, 32'h0, 0, 0);
      step(0,0,0,0,1);        check_out("fresp c1", 1, 32'h4, 0, 0);
      step(0,1,0,0,1);        check_out("fresp c2", 0, 0, 0, 0);
      step(0,0,1,32'h200,1);  check_out("fresp c3", 0, 0, 0, 0);
      step(0,0,0,0,1);        check_out("fresp c4", 1, 32'h200, 0, 0);
      step(0,0,0,0,1);        check_out("fresp c5", 1, 32'h204, 0, 0);
      step(0,0,0,0,1);        check_out("fresp c6", 0, 0, 1, 32'h200);

      // With RESET_PC=0xFFFFFFFC, the second issued address wraps to zero.
      do_reset();
      step(0,0,0,0,1);
      check("wrap first req", {31'b0, mif2.mem_req}, 32'h1);
      check("wrap first addr", mif2.mem_addr, 32'hFFFF_FFFC);
      step(0,0,0,0,1);
      check("wrap second req", {31'b0, mif2.mem_req}, 32'h1);
      check("wrap second addr", mif2.mem_addr, 32'h0000_0000);

      // A reset pulse between edges while an instruction is presented.
      do_reset();
      step(0,0,0,0,1);
      step(0,0,0,0,1);
      step(0,0,0,0,1);        check_out("pulse pre", 0, 0, 1, 32'h0);
      rst = 1'b1;
      #1;
      check("pulse instr_valid", {31'b0, mif.instr_valid}, 32'h0);
      check("pulse mem_req", {31'b0, mif.mem_req}, 32'h0);
      check("pulse pc_out", mif.pc_out, 32'h0);
      rst = 1'b0;
      pend_q.delete();
      mif.mem_rvalid = 1'b0;
      mif.mem_rdata  = 32'h0;
      #1;
      sample_accept();
      check_out("pulse rel", 1, 32'h0, 0, 0);
      step(0,0,0,0,1);        check_out("pulse c1", 1, 32'h4, 0, 0);
      step(0,0,0,0,1);        check_out("pulse c2", 0, 0, 1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
